// File: rtl/stch2dec_win.sv
// stch2dec_win -- stochastic-to-decimal window decoder.
//
// Counts the ones in the serial stochastic stream S over a window of 2^NW
// clock cycles. It then scales the count to an ND-bit probability, D = ones / 2^(NW-ND).
// The result saturates at 2^ND-1 when every sample in the window is 1.
//
// Parameters
//   ND : width of the decoded output D (probability = D / 2^ND)
//   NW : log2 of the window length in cycles; NW >= ND is required
//
// Ports
//   CLK   : clock, all state updates on the rising edge
//   INIT  : synchronous active-high reset
//   START : request one conversion window (ignored while BUSY)
//   S     : stochastic bit stream
//   D     : latest decoded probability, held between VALID pulses
//   VALID : one-cycle pulse when D is updated
//   BUSY  : high while a window is being accumulated
//
// Build option
//   STCH2DEC_CONT_EN : when defined, the first START begins back-to-back
//                      windows that repeat until INIT. BUSY stays high and
//                      further START pulses are ignored.
module stch2dec_win #(
  parameter int unsigned ND = 8,
  parameter int unsigned NW = 8
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          START,
  input  logic          S,
  output logic [ND-1:0] D,
  output logic          VALID,
  output logic          BUSY
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]    state;
  logic [NW-1:0] cyc;      // index of the sample taken on the next edge
  logic [NW:0]   ones;     // NW+1 bits so that a full window of ones fits
  logic [NW:0]   total;
  logic [NW:0]   shifted;
  logic [ND-1:0] result;
  logic          last;

  // The final sample is added combinationally, so the result is ready on
  // the same edge that samples the last bit. No extra cycle is needed.
  always_comb begin
    last    = (cyc == '1);
    total   = ones + {{NW{1'b0}}, S};
    shifted = total >> (NW - ND);
    // The scaled value can only reach 2^ND when every sample was 1.
    result  = shifted[ND] ? '1 : shifted[ND-1:0];
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state <= ST_IDLE;
      cyc   <= '0;
      ones  <= '0;
      D     <= '0;
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_ACCUM;
            cyc   <= '0;
            ones  <= '0;
          end
        end
        ST_ACCUM: begin
          if (last) begin
            D     <= result;
            VALID <= 1'b1;
            // Clear the counters on the completion edge. In continuous mode
            // the next edge then takes sample 0 of the following window,
            // with no gap between windows.
            cyc   <= '0;
            ones  <= '0;
`ifdef STCH2DEC_CONT_EN
            state <= ST_ACCUM;
`else
            state <= ST_IDLE;
`endif
          end else begin
            cyc  <= cyc + 1'b1;
            ones <= total;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (state == ST_ACCUM);

endmodule

// File: tb/tb_stch2dec_win.sv
// Directed testbench for stch2dec_win.
// Instance dut uses ND=NW=8. Instance dut10 uses ND=8, NW=10.
// Timing convention: the START edge is edge 0. The first sample is taken on
// edge 1, and the last sample on edge 2^NW. VALID is therefore high during
// cycle 2^NW+1, the period that follows edge 2^NW.
module tb_stch2dec_win;

  logic       CLK = 1'b0;
  logic       INIT, START, S;
  logic [7:0] D;
  logic       VALID, BUSY;
  logic       START10, S10;
  logic [7:0] D10;
  logic       VALID10, BUSY10;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 CLK = ~CLK;

  stch2dec_win #(.ND(8), .NW(8)) dut (
    .CLK(CLK), .INIT(INIT), .START(START), .S(S),
    .D(D), .VALID(VALID), .BUSY(BUSY)
  );

  stch2dec_win #(.ND(8), .NW(10)) dut10 (
    .CLK(CLK), .INIT(INIT), .START(START10), .S(S10),
    .D(D10), .VALID(VALID10), .BUSY(BUSY10)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus patterns, indexed by sample number within a window.
  function automatic logic pat(input int unsigned mode, input int unsigned i);
    case (mode)
      0:       pat = 1'b1;                 // constant 1
      1:       pat = 1'b0;                 // constant 0
      2:       pat = (i < 100);            // first 100 ones
      3:       pat = (i % 2 == 0);         // 1,0,1,0,...
      4:       pat = (i < 512);            // first 512 ones
      default: pat = 1'b0;
    endcase
  endfunction

  // Drive n samples into dut. VALID pulses seen before the last sample
  // are counted in early. The task returns #1 after the final-sample edge.
  task automatic feed8(input int unsigned mode, input int unsigned n, output int unsigned early);
    early = 0;
    for (int unsigned i = 0; i < n; i++) begin
      S = pat(mode, i);
      @(posedge CLK); #1;
      if (i + 1 < n && VALID) early++;
    end
  endtask

  task automatic start8();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  initial begin
    int unsigned early;
    int unsigned busy_low;
    INIT = 1'b1; START = 1'b0; S = 1'b0; START10 = 1'b0; S10 = 1'b0;
    @(posedge CLK); #1;
    check("reset_D", D, 0);
    check("reset_VALID", VALID, 0);
    check("reset_BUSY", BUSY, 0);
    INIT = 1'b0;
    @(posedge CLK); #1;

`ifndef STCH2DEC_CONT_EN
    // Constant ones: the window saturates at D=255.
    start8();
    check("s1_busy_start", BUSY, 1);
    feed8(0, 256, early);
    check("s1_early_valid", early, 0);
    check("s1_valid_257", VALID, 1);
    check("s1_D", D, 255);
    check("s1_busy_after", BUSY, 0);
    @(posedge CLK); #1;
    check("s1_valid_clear", VALID, 0);
    check("s1_D_hold", D, 255);

    // Constant zeros.
    start8();
    feed8(1, 256, early);
    check("s0_early_valid", early, 0);
    check("s0_valid", VALID, 1);
    check("s0_D", D, 0);
    @(posedge CLK); #1;
    check("s0_single_pulse", VALID, 0);

    // First 100 samples are 1.
    start8();
    feed8(2, 256, early);
    check("s100_valid", VALID, 1);
    check("s100_D", D, 100);
    @(posedge CLK); #1;

    // START held high: it is ignored mid-window, and it restarts the
    // window right after VALID.
    START = 1'b1;
    @(posedge CLK); #1;
    feed8(0, 256, early);
    check("hold_early_valid", early, 0);
    check("hold_valid", VALID, 1);
    check("hold_D", D, 255);
    check("hold_busy_gap", BUSY, 0);
    @(posedge CLK); #1;
    check("hold_restart_busy", BUSY, 1);
    check("hold_valid_clear", VALID, 0);
    START = 1'b0;
    feed8(3, 256, early);
    check("alt_early_valid", early, 0);
    check("alt_valid", VALID, 1);
    check("alt_D", D, 128);
    @(posedge CLK); #1;

    // INIT asserted after 50 samples of a window.
    start8();
    feed8(0, 50, early);
    INIT = 1'b1;
    @(posedge CLK); #1;
    INIT = 1'b0;
    check("abort_valid", VALID, 0);
    check("abort_D", D, 0);
    check("abort_busy", BUSY, 0);
    early = 0;
    for (int unsigned i = 0; i < 300; i++) begin
      S = 1'b1;
      @(posedge CLK); #1;
      if (VALID || BUSY) early++;
    end
    check("abort_no_activity", early, 0);
    start8();
    feed8(2, 256, early);
    check("after_abort_valid", VALID, 1);
    check("after_abort_D", D, 100);
    @(posedge CLK); #1;

    // NW=10: 512 ones out of 1024 samples gives D=128, VALID in cycle 1025.
    START10 = 1'b1;
    @(posedge CLK); #1;
    START10 = 1'b0;
    check("w10_busy", BUSY10, 1);
    early = 0;
    for (int unsigned i = 0; i < 1024; i++) begin
      S10 = pat(4, i);
      @(posedge CLK); #1;
      if (i < 1023 && VALID10) early++;
    end
    check("w10_early_valid", early, 0);
    check("w10_valid_1025", VALID10, 1);
    check("w10_D", D10, 128);
    check("w10_busy_after", BUSY10, 0);
`else
    // Continuous mode: ones, then zeros, with windows back to back.
    start8();
    busy_low = 0;
    early = 0;
    START = 1'b1;   // must be ignored while windows repeat
    for (int unsigned i = 0; i < 256; i++) begin
      S = 1'b1;
      @(posedge CLK); #1;
      if (!BUSY) busy_low++;
      if (i < 255 && VALID) early++;
    end
    check("c1_valid_257", VALID, 1);
    check("c1_D", D, 255);
    for (int unsigned i = 0; i < 256; i++) begin
      S = 1'b0;
      @(posedge CLK); #1;
      if (!BUSY) busy_low++;
      if (i < 255 && VALID) early++;
    end
    START = 1'b0;
    check("c2_valid_513", VALID, 1);
    check("c2_D", D, 0);
    check("c_busy_never_low", busy_low, 0);
    check("c_early_valid", early, 0);
    S = 1'b1;
    @(posedge CLK); #1;
    check("c_valid_clear", VALID, 0);
    check("c_busy_still", BUSY, 1);
    INIT = 1'b1;
    @(posedge CLK); #1;
    INIT = 1'b0;
    check("c_init_busy", BUSY, 0);
    check("c_init_D", D, 0);
    check("c_init_valid", VALID, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
